// File: rtl/corr_event_collector.sv
// Collects correlator CorrelationSeen rising edges into an event FIFO drained over the register bus.
// Optional `CORR_EVT_TIMESTAMP_EN stores the SampleCount timestamp with each entry.
module corr_event_collector #(
    parameter int unsigned DEPTH = 16,
    parameter logic [31:0] BASE  = 32'hFE000900
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] Wdata,
    input  logic        write,
    input  logic        read,
    output logic [31:0] Rdata,
    input  logic [31:0] CorrSeen,
    input  logic [31:0] SampleCount,
    output logic        irq
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
`ifdef CORR_EVT_TIMESTAMP_EN
    localparam int unsigned EW = 37;
`else
    localparam int unsigned EW = 5;
`endif

    logic [31:0]   cur_q, prev_q, pending_q, pending_d, sticky_q, mask_q;
    logic          enable_q, irq_en_q, overflow_q, irq_q;
    logic [7:0]    level_q;
    logic [15:0]   drop_q, drop_d;
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q;
    logic [EW-1:0] mem [DEPTH];

    logic          hit;
    logic [2:0]    idx;
    logic          wr_ctrl, wr_mask, wr_sticky, wr_level, clear, pop;
    logic          empty, full, push, do_write, ovf_drop, irq_d;
    logic [31:0]   cap, merged, scan_oh;
    logic [4:0]    scan_idx;
    logic [5:0]    merge_cnt;
    logic [16:0]   drop_sum;
    logic [7:0]    level_eff;
    logic [EW-1:0] entry, head;
    logic [31:0]   head_ts, rdata_mux;

    assign hit       = (addr[31:5] == BASE[31:5]) && (addr[1:0] == 2'b00);
    assign idx       = addr[4:2];
    assign wr_ctrl   = write && hit && (idx == 3'd0);
    assign wr_mask   = write && hit && (idx == 3'd2);
    assign wr_sticky = write && hit && (idx == 3'd3);
    assign wr_level  = write && hit && (idx == 3'd7);
    assign clear     = wr_ctrl && Wdata[2];

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign pop   = read && hit && (idx == 3'd5) && !empty;

    // Edge detect on the registered copy; cur_q/prev_q both reset to 0.
    assign cap     = cur_q & ~prev_q & mask_q & {32{enable_q}};
    assign scan_oh = pending_q & (~pending_q + 32'd1);
    assign merged  = cap & pending_q & ~scan_oh;

    always_comb begin
        scan_idx  = '0;
        merge_cnt = '0;
        for (int i = 31; i >= 0; i--) begin
            if (pending_q[i]) scan_idx = 5'(i);
            merge_cnt = merge_cnt + 6'(merged[i]);
        end
    end

    assign push     = |pending_q;
    assign do_write = push && (!full || pop) && !clear;
    assign ovf_drop = push && full && !pop;

    assign pending_d = clear ? '0 : ((pending_q & ~scan_oh) | cap);
    assign drop_sum  = {1'b0, drop_q} + 17'(merge_cnt) + 17'(ovf_drop);
    assign drop_d    = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

    assign level_eff = (level_q == 8'd0) ? 8'd1 : level_q;
    assign irq_d     = irq_en_q && ((8'(count_q) >= level_eff) || overflow_q);
    assign irq       = irq_q;

`ifdef CORR_EVT_TIMESTAMP_EN
    assign entry   = {SampleCount, scan_idx};
    assign head    = mem[rptr_q];
    assign head_ts = head[36:5];
`else
    logic unused_sample_count;
    assign unused_sample_count = ^SampleCount;
    assign entry   = scan_idx;
    assign head    = mem[rptr_q];
    assign head_ts = 32'd0;
`endif

    always_ff @(posedge clk) begin
        if (do_write) mem[wptr_q] <= entry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_q      <= '0;
            prev_q     <= '0;
            pending_q  <= '0;
            sticky_q   <= '0;
            mask_q     <= '1;
            enable_q   <= 1'b0;
            irq_en_q   <= 1'b0;
            overflow_q <= 1'b0;
            irq_q      <= 1'b0;
            level_q    <= 8'd1;
            drop_q     <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
        end else begin
            cur_q     <= CorrSeen;
            prev_q    <= cur_q;
            pending_q <= pending_d;
            sticky_q  <= (sticky_q & ~(wr_sticky ? Wdata : 32'd0)) | cap;
            irq_q     <= irq_d;
            if (wr_ctrl) begin
                enable_q <= Wdata[0];
                irq_en_q <= Wdata[1];
            end
            if (wr_mask)  mask_q  <= Wdata;
            if (wr_level) level_q <= Wdata[7:0];
            if (clear) begin
                wptr_q     <= '0;
                rptr_q     <= '0;
                count_q    <= '0;
                overflow_q <= 1'b0;
                drop_q     <= '0;
            end else begin
                if (do_write) wptr_q <= wptr_q + AW'(1);
                if (pop)      rptr_q <= rptr_q + AW'(1);
                count_q <= count_q + CW'(do_write) - CW'(pop);
                if (ovf_drop) overflow_q <= 1'b1;
                drop_q <= drop_d;
            end
        end
    end

    always_comb begin
        rdata_mux = '0;
        case (idx)
            3'd0: rdata_mux = {30'd0, irq_en_q, enable_q};
            3'd1: rdata_mux = {21'd0, overflow_q, full, empty, 8'(count_q)};
            3'd2: rdata_mux = mask_q;
            3'd3: rdata_mux = sticky_q;
            3'd4: rdata_mux = empty ? 32'd0 : head_ts;
            3'd5: rdata_mux = empty ? 32'd0 : {1'b1, 26'd0, head[4:0]};
            3'd6: rdata_mux = {16'd0, drop_q};
            3'd7: rdata_mux = {24'd0, level_q};
            default: rdata_mux = '0;
        endcase
    end

    assign Rdata = (read && hit && !rst) ? rdata_mux : 32'd0;

endmodule
